// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync header, deserialises an MSB-first payload,
// checks even parity and keeps good-frame / parity-error counters.
module serial_frame_rx #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1101,
    parameter int unsigned       CNT_W    = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              din,
    input  logic              en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              par_err,
    output logic              in_frame,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned BCNT_W = $clog2(DATA_W);

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;

    logic [1:0]        state_q,     state_d;
    // Only the youngest SYNC_W-1 header bits are ever needed for the next match.
    logic [SYNC_W-2:0] sync_sr_q,   sync_sr_d;
    logic [DATA_W-1:0] data_sr_q,   data_sr_d;
    logic [BCNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0] data_out_q,  data_out_d;
    logic              valid_q,     valid_d;
    logic              par_err_q,   par_err_d;
    logic              in_frame_q,  in_frame_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;

    logic [SYNC_W-1:0] sync_shift;
    logic              parity_odd;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        sync_sr_d   = sync_sr_q;
        data_sr_d   = data_sr_q;
        bit_cnt_d   = bit_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        par_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        sync_shift  = {sync_sr_q, din};
        parity_odd  = (^data_sr_q) ^ din;

        if (en) begin
            case (state_q)
                ST_HUNT: begin
                    sync_sr_d = sync_shift[SYNC_W-2:0];
                    if (sync_shift == SYNC_PAT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    data_sr_d = {data_sr_q[DATA_W-2:0], din};
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q == BCNT_W'(DATA_W - 1)) begin
                        state_d = ST_PAR;
                    end
                end
                ST_PAR: begin
                    if (!parity_odd) begin
                        data_out_d  = data_sr_q;
                        valid_d     = 1'b1;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end else begin
                        par_err_d = 1'b1;
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                    // Clearing the history forces a fresh header after every frame.
                    state_d   = ST_HUNT;
                    sync_sr_d = '0;
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        in_frame_d = (state_d != ST_HUNT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_HUNT;
            sync_sr_q   <= '0;
            data_sr_q   <= '0;
            bit_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            in_frame_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync_sr_q   <= sync_sr_d;
            data_sr_q   <= data_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            in_frame_q  <= in_frame_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign par_err   = par_err_q;
    assign in_frame  = in_frame_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus random bit streams, each cycle compared
// against a bit-list reference model of the framing rules.
module tb_serial_frame_rx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              clr;
    logic              din;
    logic              en;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              par_err;
    logic              in_frame;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;

    int checks   = 0;
    int failures = 0;
    int v_seen   = 0;

    // Reference model: position within a frame (-1 = hunting), recent header bits, payload.
    int         m_pos;
    int         m_hist;
    logic [7:0] m_pay;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_perr;
    int         e_fcnt;
    int         e_ecnt;

    serial_frame_rx dut (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .en        (en),
        .data_out  (data_out),
        .valid     (valid),
        .par_err   (par_err),
        .in_frame  (in_frame),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos   = -1;
        m_hist  = 0;
        m_pay   = '0;
        e_data  = '0;
        e_valid = 1'b0;
        e_perr  = 1'b0;
        e_fcnt  = 0;
        e_ecnt  = 0;
    endtask

    task automatic model_bit(input int b);
        e_valid = 1'b0;
        e_perr  = 1'b0;
        if (m_pos < 0) begin
            m_hist = ((m_hist << 1) | b) & 15;
            if (m_hist == 13) m_pos = 0;
        end else if (m_pos < 8) begin
            m_pay = {m_pay[6:0], b[0]};
            m_pos++;
        end else begin
            if ((($countones(m_pay) + b) % 2) == 0) begin
                e_data  = m_pay;
                e_valid = 1'b1;
                e_fcnt  = (e_fcnt + 1) % 256;
            end else begin
                e_perr = 1'b1;
                if (e_ecnt < 255) e_ecnt++;
            end
            m_pos  = -1;
            m_hist = 0;
        end
    endtask

    task automatic chk_all();
        chk("data_out",  32'(data_out),  32'(e_data));
        chk("valid",     32'(valid),     32'(e_valid));
        chk("par_err",   32'(par_err),   32'(e_perr));
        chk("in_frame",  32'(in_frame),  32'(m_pos >= 0));
        chk("frame_cnt", 32'(frame_cnt), 32'(e_fcnt));
        chk("err_cnt",   32'(err_cnt),   32'(e_ecnt));
        chk("strobe_excl", 32'(valid & par_err), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data_out"},  32'(data_out),  32'd0);
        chk({tag, "_valid"},     32'(valid),     32'd0);
        chk({tag, "_par_err"},   32'(par_err),   32'd0);
        chk({tag, "_in_frame"},  32'(in_frame),  32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    endtask

    // One clock: drive inputs, advance the model on enabled edges, compare everything.
    task automatic cycle(input int b, input logic e);
        din = b[0];
        en  = e;
        @(posedge clk);
        #1;
        if (e) begin
            model_bit(b);
        end else begin
            e_valid = 1'b0;
            e_perr  = 1'b0;
        end
        if (valid) v_seen++;
        chk_all();
    endtask

    task automatic pulse_reset(input string tag);
        clr = 1'b0;
        #1;
        chk_zero(tag);
        model_reset();
        clr = 1'b1;
        #1;
    endtask

    task automatic send_bit(input int b, input bit gap);
        cycle(b, 1'b1);
        if (gap) cycle(int'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] pay, input int par, input bit gap);
        logic [3:0] hdr;
        hdr = 4'b1101;
        for (int i = 3; i >= 0; i--) send_bit(int'(hdr[i]), gap);
        for (int i = 7; i >= 0; i--) send_bit(int'(pay[i]), gap);
        send_bit(par, gap);
    endtask

    function automatic int even_par(input logic [7:0] pay);
        return $countones(pay) % 2;
    endfunction

    initial begin
        clr = 1'b0;
        din = 1'b0;
        en  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("reset");
        clr = 1'b1;
        #1;

        // Test 1: 0000 then frame 0xA5 with good parity
        for (int i = 0; i < 4; i++) cycle(0, 1'b1);
        send_frame(8'hA5, 0, 1'b0);
        chk("t1_data", 32'(data_out), 32'hA5);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_err_cnt", 32'(err_cnt), 32'd0);

        // Test 2: same frame, bad parity; data_out keeps 0xA5
        send_frame(8'hA5, 1, 1'b0);
        chk("t2_err_cnt", 32'(err_cnt), 32'd1);
        chk("t2_data_hold", 32'(data_out), 32'hA5);

        // Test 3: good frame with en on alternate cycles
        pulse_reset("t3_reset");
        send_frame(8'hA5, 0, 1'b1);
        cycle(0, 1'b0);
        chk("t3_data", 32'(data_out), 32'hA5);
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd1);

        // Test 4: payload containing the header pattern, then a back-to-back frame
        pulse_reset("t4_reset");
        v_seen = 0;
        send_frame(8'h0D, 1, 1'b0);
        chk("t4_first_data", 32'(data_out), 32'h0D);
        send_frame(8'h3C, 0, 1'b0);
        cycle(0, 1'b1);
        chk("t4_valid_count", 32'(v_seen), 32'd2);
        chk("t4_data", 32'(data_out), 32'h3C);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd2);

        // Test 5: reset after four payload bits, then a clean 0x5A frame
        pulse_reset("t5_pre");
        for (int i = 3; i >= 0; i--) cycle(i == 1 ? 0 : 1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(i % 2, 1'b1);
        pulse_reset("t5_abort");
        cycle(0, 1'b1);
        chk("t5_no_strobe", 32'(valid | par_err), 32'd0);
        send_frame(8'h5A, 0, 1'b0);
        chk("t5_data", 32'(data_out), 32'h5A);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);

        // Random stream with random enables
        for (int i = 0; i < 600; i++) begin
            cycle(int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        // Random frames: random payload, random parity, random gaps
        for (int i = 0; i < 40; i++) begin
            logic [7:0] p;
            p = 8'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) cycle(0, 1'b1);
            send_frame(p, int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Test 6: error-counter saturation and frame-counter wrap
        pulse_reset("t6_reset");
        for (int i = 0; i < 300; i++) begin
            logic [7:0] p;
            p = 8'($urandom);
            send_frame(p, 1 - even_par(p), 1'b0);
        end
        chk("t6_err_sat", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 257; i++) begin
            logic [7:0] p;
            p = 8'($urandom);
            send_frame(p, even_par(p), 1'b0);
        end
        chk("t6_frame_wrap", 32'(frame_cnt), 32'd1);
        chk("t6_err_hold", 32'(err_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
